// File: rtl/pipeline_ctrl_pkg.sv
// Pipeline control shared definitions: controller states, stage-priority
// selectors and the per-stage enable/flush bundle.
package pipeline_ctrl_pkg;

   localparam int CNT_W = 32;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   typedef enum logic [2:0] {
      PRI_BOOT,
      PRI_MEM,
      PRI_EXB,
      PRI_FLUSH,
      PRI_STALL,
      PRI_NORM,
      PRI_HALT
   } pri_e;

   typedef struct packed {
      logic pc_we;
      logic if_we;
      logic if_fl;
      logic id_we;
      logic id_fl;
      logic ex_we;
      logic ex_fl;
      logic mem_we;
   } ctl_t;

   function automatic ctl_t ctl_of(pri_e pri);
      ctl_t c;
      c = '0;
      c.pc_we  = 1'b1;
      c.if_we  = 1'b1;
      c.id_we  = 1'b1;
      c.ex_we  = 1'b1;
      c.mem_we = 1'b1;
      case (pri)
         PRI_BOOT: begin
            c = '0;
            c.if_fl = 1'b1;
            c.id_fl = 1'b1;
            c.ex_fl = 1'b1;
         end
         PRI_MEM: c = '0;
         PRI_EXB: begin
            c.pc_we = 1'b0;
            c.if_we = 1'b0;
            c.id_we = 1'b0;
            c.ex_fl = 1'b1;
         end
         PRI_FLUSH: begin
            c.if_fl = 1'b1;
            c.id_fl = 1'b1;
         end
         // bubble into ID/EX; older stages keep draining
         PRI_STALL, PRI_HALT: begin
            c.pc_we = 1'b0;
            c.if_we = 1'b0;
            c.id_fl = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running performance counter with enable and synchronous reset.
// Wraps modulo 2^CNT_W.
module perf_counter
   import pipeline_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (en)
         cnt_q <= cnt_q + 1'b1;
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: boot hold, hazard/flush arbitration,
// debug halt with drain, and performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int RESET_HOLD   = 4,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stall,
   input  logic        ex_flush,
   input  logic        ex_busy,
   input  logic        mem_busy,
   input  logic        halt_req,
   input  logic        resume,
   output logic        pc_we,
   output logic        if_reg_we,
   output logic        if_reg_flush,
   output logic        id_reg_we,
   output logic        id_reg_flush,
   output logic        ex_reg_we,
   output logic        ex_reg_flush,
   output logic        mem_reg_we,
   output logic        halted,
   output logic [31:0] cycle_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   logic [1:0]  state;
   logic [15:0] boot_cnt;
   logic [15:0] drain_cnt;
   logic        flush_pend;
   logic        halted_q;

   logic in_boot, in_run, in_halt;
   logic run_ok, want_flush;
   pri_e pri;
   ctl_t ctl;

   assign in_run  = !rst && (state == ST_RUN);
   assign in_halt = !rst && (state == ST_HALT);
   assign in_boot = !in_run && !in_halt;

   assign run_ok     = in_run && !mem_busy && !ex_busy;
   assign want_flush = ex_flush || flush_pend;

   always_comb begin
      pri = PRI_NORM;
      unique case (1'b1)
         in_boot:                           pri = PRI_BOOT;
         !in_boot && mem_busy:              pri = PRI_MEM;
         in_run && !mem_busy && ex_busy:    pri = PRI_EXB;
         run_ok && want_flush:              pri = PRI_FLUSH;
         run_ok && !want_flush && id_stall: pri = PRI_STALL;
         in_halt && !mem_busy:              pri = PRI_HALT;
         default:                           pri = PRI_NORM;
      endcase
   end

   assign ctl = ctl_of(pri);

   assign pc_we        = ctl.pc_we;
   assign if_reg_we    = ctl.if_we;
   assign if_reg_flush = ctl.if_fl;
   assign id_reg_we    = ctl.id_we;
   assign id_reg_flush = ctl.id_fl;
   assign ex_reg_we    = ctl.ex_we;
   assign ex_reg_flush = ctl.ex_fl;
   assign mem_reg_we   = ctl.mem_we;
   assign halted       = halted_q && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BOOT;
         boot_cnt   <= '0;
         drain_cnt  <= '0;
         flush_pend <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               // a flush seen while frozen must still squash once released
               if (pri == PRI_FLUSH)
                  flush_pend <= 1'b0;
               else if (ex_flush && (pri == PRI_MEM || pri == PRI_EXB))
                  flush_pend <= 1'b1;
               if (halt_req && !mem_busy) begin
                  state     <= ST_HALT;
                  drain_cnt <= '0;
                  halted_q  <= 1'b0;
               end
            end
            ST_HALT: begin
               if (resume) begin
                  state     <= ST_RUN;
                  drain_cnt <= '0;
                  halted_q  <= 1'b0;
               end else if (!mem_busy) begin
                  if (drain_cnt == 16'(DRAIN_CYCLES - 1))
                     halted_q <= 1'b1;
                  if (drain_cnt < 16'(DRAIN_CYCLES))
                     drain_cnt <= drain_cnt + 16'd1;
               end
            end
            default: begin
               if (boot_cnt == 16'(RESET_HOLD - 1)) begin
                  state    <= ST_RUN;
                  boot_cnt <= '0;
               end else begin
                  boot_cnt <= boot_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   logic cyc_en, stall_en, flush_en;

   assign cyc_en   = in_run || in_halt;
   assign stall_en = in_run && !ctl.pc_we;
   assign flush_en = (pri == PRI_FLUSH);

   perf_counter u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (cyc_en),
      .count (cycle_cnt)
   );

   perf_counter u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_en),
      .count (stall_cnt)
   );

   perf_counter u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (flush_en),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: reference model pushes expectations,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

   localparam int RH = 4;
   localparam int DC = 3;

   logic clk = 1'b0;
   logic rst, id_stall, ex_flush, ex_busy, mem_busy, halt_req, resume;
   logic pc_we, if_reg_we, if_reg_flush, id_reg_we, id_reg_flush;
   logic ex_reg_we, ex_reg_flush, mem_reg_we, halted;
   logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl #(.RESET_HOLD(RH), .DRAIN_CYCLES(DC)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_stall     (id_stall),
      .ex_flush     (ex_flush),
      .ex_busy      (ex_busy),
      .mem_busy     (mem_busy),
      .halt_req     (halt_req),
      .resume       (resume),
      .pc_we        (pc_we),
      .if_reg_we    (if_reg_we),
      .if_reg_flush (if_reg_flush),
      .id_reg_we    (id_reg_we),
      .id_reg_flush (id_reg_flush),
      .ex_reg_we    (ex_reg_we),
      .ex_reg_flush (ex_reg_flush),
      .mem_reg_we   (mem_reg_we),
      .halted       (halted),
      .cycle_cnt    (cycle_cnt),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   typedef struct packed {
      logic [8:0]  ctl;
      logic [31:0] cyc;
      logic [31:0] stl;
      logic [31:0] fls;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;

   typedef enum {M_BOOT, M_RUN, M_HALT} mode_e;
   mode_e       m_mode  = M_BOOT;
   int          m_boot  = 0;
   int          m_drain = 0;
   bit          m_pend  = 0;
   bit          m_halt  = 0;
   logic [31:0] m_cyc   = '0;
   logic [31:0] m_stl   = '0;
   logic [31:0] m_fls   = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("ctl", {23'd0, pc_we, if_reg_we, if_reg_flush, id_reg_we,
                     id_reg_flush, ex_reg_we, ex_reg_flush, mem_reg_we,
                     halted}, {23'd0, e.ctl});
         chk("cycle_cnt", cycle_cnt, e.cyc);
         chk("stall_cnt", stall_cnt, e.stl);
         chk("flush_cnt", flush_cnt, e.fls);
      end
   end

   // Drive one cycle, predict its outputs, advance the model past the edge.
   task automatic step(input bit r, input bit st, input bit ef,
                       input bit eb, input bit mb, input bit hr,
                       input bit rs);
      bit p, iw, ifl, dw, dfl, ew, efl, mw, h, fc;
      exp_t e;
      rst = r; id_stall = st; ex_flush = ef; ex_busy = eb;
      mem_busy = mb; halt_req = hr; resume = rs;
      fc = 0;
      h = m_halt && !r;
      p = 1; iw = 1; dw = 1; ew = 1; mw = 1;
      ifl = 0; dfl = 0; efl = 0;
      if (r || m_mode == M_BOOT) begin
         {p, iw, dw, ew, mw} = 5'b00000;
         {ifl, dfl, efl} = 3'b111;
      end else if (mb) begin
         {p, iw, dw, ew, mw} = 5'b00000;
      end else if (m_mode == M_HALT) begin
         p = 0; iw = 0; dfl = 1;
      end else if (eb) begin
         p = 0; iw = 0; dw = 0; efl = 1;
      end else if (ef || m_pend) begin
         ifl = 1; dfl = 1; fc = 1;
      end else if (st) begin
         p = 0; iw = 0; dfl = 1;
      end
      e.ctl = {p, iw, ifl, dw, dfl, ew, efl, mw, h};
      e.cyc = m_cyc;
      e.stl = m_stl;
      e.fls = m_fls;
      sb_q.push_back(e);
      if (r) begin
         m_mode = M_BOOT; m_boot = 0; m_drain = 0;
         m_pend = 0; m_halt = 0;
         m_cyc = '0; m_stl = '0; m_fls = '0;
      end else begin
         if (m_mode != M_BOOT) m_cyc++;
         if (m_mode == M_RUN && !p) m_stl++;
         if (fc) m_fls++;
         case (m_mode)
            M_BOOT: begin
               m_boot++;
               if (m_boot == RH) m_mode = M_RUN;
            end
            M_RUN: begin
               if (fc) m_pend = 0;
               else if (ef && (mb || eb)) m_pend = 1;
               if (hr && !mb) begin
                  m_mode = M_HALT; m_drain = 0; m_halt = 0;
               end
            end
            M_HALT: begin
               if (rs) begin
                  m_mode = M_RUN; m_halt = 0;
               end else if (!mb) begin
                  m_drain++;
                  if (m_drain >= DC) m_halt = 1;
               end
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   logic [31:0] s0;

   initial begin
      rst = 1; id_stall = 0; ex_flush = 0; ex_busy = 0;
      mem_busy = 0; halt_req = 0; resume = 0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0, 0, 0);

      // boot hold then first RUN cycle
      for (int i = 0; i < RH; i++) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("boot_first_run_cycle_cnt", cycle_cnt, 32'd1);

      s0 = stall_cnt;
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("id_stall_delta", stall_cnt - s0, 32'd2);

      s0 = flush_cnt;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      idle(2);
      chk("pend_flush_delta", flush_cnt - s0, 32'd1);

      s0 = stall_cnt;
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
      chk("ex_busy_delta", stall_cnt - s0, 32'd5);

      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("halted_early", {31'd0, halted}, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("halted_rise", {31'd0, halted}, 32'd1);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("halted_clear", {31'd0, halted}, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("run_after_resume", {31'd0, pc_we}, 32'd1);

      // reset in the middle of a drain and with a pending flush
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(RH + 2);
      step(0, 0, 1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(RH + 2);

      force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_cycle_cnt.cnt_q;
      m_cyc = 32'hFFFF_FFFF;
      step(0, 0, 0, 0, 0, 0, 0);
      chk("cycle_cnt_wrap", cycle_cnt, 32'h0000_0000);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 7) == 0);
      end
      idle(2);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
